// File: rtl/pll_tuner_pkg.sv
// Shared types and helpers for the PLL phase tuner.
// Optional build macro PLL_TUNER_ABS_EN adds the CALC state used by
// absolute-target requests.
package pll_tuner_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PULSE     = 3'd3,
    ST_GAP       = 3'd4
`ifdef PLL_TUNER_ABS_EN
    ,ST_CALC     = 3'd5
`endif
  } tuner_state_e;

  // Bit positions inside err_o
  localparam int ERR_LOCK_LOST = 0;
  localparam int ERR_BAD_CH    = 1;
  localparam int ERR_W         = 2;

  // One modular step of a phase counter. The mask is PHASE_STEPS-1, so the
  // wrap is exact for any power-of-two step count up to 256.
  function automatic logic [7:0] phase_mod_step(input logic [7:0] ph,
                                                input logic       adv,
                                                input logic [7:0] mask);
    logic [7:0] nxt;
    nxt = adv ? (ph + 8'd1) : (ph - 8'd1);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Lock qualifier: 2-FF synchroniser for the raw PLL lock, a consecutive-cycle
// filter that raises lock_stable, and the downstream reset that trails it.
module pll_lock_filter
  import pll_tuner_pkg::*;
#(
  parameter int LOCK_FILT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  output logic lock_sync,
  output logic lock_stable,
  output logic rst_out_n
);

  localparam int CW = $clog2(LOCK_FILT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_FILT - 1);

  logic          lock_p0;
  logic          lock_p1;
  logic [CW-1:0] cnt;

  assign lock_sync = lock_p1;

  // Synchronise raw lock, count consecutive locked cycles, derive reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_p0     <= 1'b0;
      lock_p1     <= 1'b0;
      cnt         <= '0;
      lock_stable <= 1'b0;
      rst_out_n   <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability settling
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;
      // filter stage: any unlocked sample restarts qualification at once
      if (!lock_p1) begin
        cnt         <= '0;
        lock_stable <= 1'b0;
      end else begin
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        if (cnt == CNT_LAST) lock_stable <= 1'b1;
      end
      rst_out_n <= lock_stable;
    end
  end

endmodule

// File: rtl/pll_phase_tuner.sv
// Run-time controller for the PLL dynamic phase-shift port. Accepts per
// channel step requests, sequences PSSEL/PSDIR/PSPULSE, tracks each channel's
// phase and gates everything on a filtered PLL lock.
// Build macro PLL_TUNER_ABS_EN: req_steps becomes an absolute target phase and
// the shortest direction is chosen in an extra CALC cycle.
module pll_phase_tuner
  import pll_tuner_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int PHASE_STEPS = 16,
  parameter int PHASE_W     = 4,
  parameter int PULSE_LEN   = 4,
  parameter int GAP_LEN     = 8,
  parameter int LOCK_FILT   = 1024
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      pll_lock,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [2:0]                req_ch,
  input  logic                      req_dir,
  input  logic [PHASE_W-1:0]        req_steps,
  output logic [2:0]                ps_sel,
  output logic                      ps_dir,
  output logic                      ps_pulse,
  output logic                      busy,
  output logic [NUM_CH*PHASE_W-1:0] phase_o,
  output logic                      lock_stable,
  output logic                      rst_out_n,
  output logic [ERR_W-1:0]          err_o
);

  localparam int CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [2:0]       CH_LIMIT   = 3'(NUM_CH);
  localparam logic [7:0]       PHASE_MASK = 8'(PHASE_STEPS - 1);

  tuner_state_e              state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PHASE_W-1:0]        steps_q, steps_d;
  logic [2:0]                ps_sel_d;
  logic                      ps_dir_d;
  logic                      ps_pulse_d;
  logic                      busy_d;
  logic [ERR_W-1:0]          err_d;
  logic [NUM_CH*PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0]        sel_phase;
  logic [PHASE_W-1:0]        stepped_phase;
  logic                      lock_sync;
  logic                      lock_ok;

  pll_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filter (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .pll_lock    (pll_lock),
    .lock_sync   (lock_sync),
    .lock_stable (lock_stable),
    .rst_out_n   (rst_out_n)
  );

  // Checking the synchronised lock as well reacts one cycle before the
  // filtered flag drops, keeping the pulse abort fast.
  assign lock_ok   = lock_stable & lock_sync;
  assign req_ready = (state_q == ST_IDLE) && lock_ok;
  assign phase_o   = phase_q;

  // Phase of the channel currently driven on ps_sel, and its next value
  always_comb begin
    sel_phase = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ps_sel == 3'(k)) sel_phase = phase_q[k*PHASE_W +: PHASE_W];
    end
    stepped_phase = PHASE_W'(phase_mod_step(8'(sel_phase), ps_dir, PHASE_MASK));
  end

`ifdef PLL_TUNER_ABS_EN
  localparam logic [PHASE_W-1:0] HALF = PHASE_W'(PHASE_STEPS / 2);

  logic [PHASE_W-1:0] req_phase;
  logic [PHASE_W-1:0] abs_delta;

  // Forward distance from the requested channel's phase to the target
  always_comb begin
    req_phase = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_ch == 3'(k)) req_phase = phase_q[k*PHASE_W +: PHASE_W];
    end
    abs_delta = req_steps - req_phase;
  end
`endif

  // Next-state and output decode for the step sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    steps_d    = steps_q;
    ps_sel_d   = ps_sel;
    ps_dir_d   = ps_dir;
    ps_pulse_d = 1'b0;
    busy_d     = busy;
    err_d      = err_o;
    phase_d    = phase_q;

    if (!lock_ok && state_q != ST_WAIT_LOCK) begin
      // Abandon any step in flight; a cut-short pulse is not counted
      state_d = ST_WAIT_LOCK;
      busy_d  = 1'b0;
      if (state_q != ST_IDLE) err_d[ERR_LOCK_LOST] = 1'b1;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_ok) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (req_valid) begin
            if (req_ch >= CH_LIMIT) begin
              err_d[ERR_BAD_CH] = 1'b1;
`ifdef PLL_TUNER_ABS_EN
            end else if (abs_delta != '0) begin
              ps_sel_d = req_ch;
              steps_d  = abs_delta;
              busy_d   = 1'b1;
              state_d  = ST_CALC;
            end
`else
            end else if (req_steps != '0) begin
              ps_sel_d = req_ch;
              ps_dir_d = req_dir;
              steps_d  = req_steps;
              busy_d   = 1'b1;
              state_d  = ST_SETUP;
            end
`endif
          end
        end
`ifdef PLL_TUNER_ABS_EN
        ST_CALC: begin
          // Shortest way round: advance up to half a period, else retard
          if (steps_q <= HALF) begin
            ps_dir_d = 1'b1;
          end else begin
            ps_dir_d = 1'b0;
            steps_d  = -steps_q;
          end
          state_d = ST_SETUP;
        end
`endif
        ST_SETUP: begin
          cnt_d      = '0;
          ps_pulse_d = 1'b1;
          state_d    = ST_PULSE;
        end
        ST_PULSE: begin
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            steps_d = steps_q - 1'b1;
            state_d = ST_GAP;
            for (int k = 0; k < NUM_CH; k++) begin
              if (ps_sel == 3'(k)) phase_d[k*PHASE_W +: PHASE_W] = stepped_phase;
            end
          end else begin
            cnt_d      = cnt_q + 1'b1;
            ps_pulse_d = 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (steps_q == '0) begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              ps_pulse_d = 1'b1;
              state_d    = ST_PULSE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  // Sequencer state and registered PLL-facing outputs
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      steps_q  <= '0;
      ps_sel   <= '0;
      ps_dir   <= 1'b0;
      ps_pulse <= 1'b0;
      busy     <= 1'b0;
      err_o    <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      ps_sel   <= ps_sel_d;
      ps_dir   <= ps_dir_d;
      ps_pulse <= ps_pulse_d;
      busy     <= busy_d;
      err_o    <= err_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: tb/tb_pll_phase_tuner.sv
// Directed bench for pll_phase_tuner (NUM_CH=2, 16 steps, 4/8 pulse/gap,
// LOCK_FILT=16). Follows PLL_TUNER_ABS_EN when defined.
module tb_pll_phase_tuner;

`ifdef PLL_TUNER_ABS_EN
  localparam int ABS = 1;
`else
  localparam int ABS = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       pll_lock;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_ch;
  logic       req_dir;
  logic [3:0] req_steps;
  logic [2:0] ps_sel;
  logic       ps_dir;
  logic       ps_pulse;
  logic       busy;
  logic [7:0] phase_o;
  logic       lock_stable;
  logic       rst_out_n;
  logic [1:0] err_o;

  int total = 0;
  int bad   = 0;

  pll_phase_tuner #(
    .NUM_CH      (2),
    .PHASE_STEPS (16),
    .PHASE_W     (4),
    .PULSE_LEN   (4),
    .GAP_LEN     (8),
    .LOCK_FILT   (16)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pll_lock    (pll_lock),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_ch      (req_ch),
    .req_dir     (req_dir),
    .req_steps   (req_steps),
    .ps_sel      (ps_sel),
    .ps_dir      (ps_dir),
    .ps_pulse    (ps_pulse),
    .busy        (busy),
    .phase_o     (phase_o),
    .lock_stable (lock_stable),
    .rst_out_n   (rst_out_n),
    .err_o       (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it until busy falls (bounded)
  task automatic run_req(input logic [2:0] ch, input logic dir, input logic [3:0] steps,
                         input logic exp_dir, output int busy_n, output int hi,
                         output int rises, output int bad_drv);
    logic prev;
    int   guard;
    req_valid = 1'b1;
    req_ch    = ch;
    req_dir   = dir;
    req_steps = steps;
    tick;
    req_valid = 1'b0;
    busy_n = 0; hi = 0; rises = 0; bad_drv = 0; prev = 1'b0; guard = 0;
    while (busy && guard < 200) begin
      busy_n++;
      if (ps_pulse) begin
        hi++;
        if (!prev) rises++;
        if (ps_sel !== ch || ps_dir !== exp_dir) bad_drv++;
      end
      prev = ps_pulse;
      tick;
      guard++;
    end
  endtask

  int busy_n, hi, rises, bad_drv, n;

  initial begin
    sys_rst_n = 1'b0;
    pll_lock  = 1'b1;
    req_valid = 1'b0;
    req_ch    = 3'd0;
    req_dir   = 1'b0;
    req_steps = 4'd0;
    repeat (3) tick;

    // Reset state
    check("rst_ps_pulse", ps_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_lock_stable", lock_stable, 0);
    check("rst_rst_out_n", rst_out_n, 0);
    check("rst_err", err_o, 0);
    check("rst_phase", phase_o, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_ps_sel", ps_sel, 0);

    // Lock qualification: lock_stable on the 18th edge, rst_out_n on the 19th
    sys_rst_n = 1'b1;
    repeat (17) tick;
    check("lock_early", lock_stable, 0);
    tick;
    check("lock_rise", lock_stable, 1);
    check("rst_out_lag", rst_out_n, 0);
    tick;
    check("rst_out_rise", rst_out_n, 1);
    check("ready_after_lock", req_ready, 1);

    // ch1 advance 3 (absolute mode: target 3 from 0)
    run_req(3'd1, 1'b1, 4'd3, 1'b1, busy_n, hi, rises, bad_drv);
    check("t1_busy_cycles", busy_n, 37 + ABS);
    check("t1_pulse_high", hi, 12);
    check("t1_pulse_count", rises, 3);
    check("t1_sel_dir", bad_drv, 0);
    check("t1_phase", phase_o, 8'h30);
    check("t1_pulse_idle", ps_pulse, 0);

    // ch0 retard 1 from 0 wraps to 15 (absolute mode: target 15)
    run_req(3'd0, 1'b0, (ABS != 0) ? 4'd15 : 4'd1, 1'b0, busy_n, hi, rises, bad_drv);
    check("t2_busy_cycles", busy_n, 13 + ABS);
    check("t2_pulse_count", rises, 1);
    check("t2_pulse_high", hi, 4);
    check("t2_sel_dir", bad_drv, 0);
    check("t2_phase_wrap", phase_o, 8'h3F);
    check("t2_sel_hold", ps_sel, 0);
    check("t2_dir_hold", ps_dir, 0);

    // No-op request: zero steps, or target equal to current phase
    run_req(3'd1, 1'b1, (ABS != 0) ? 4'd3 : 4'd0, 1'b1, busy_n, hi, rises, bad_drv);
    check("noop_busy", busy_n, 0);
    check("noop_phase", phase_o, 8'h3F);
    check("noop_err", err_o, 0);

    // Illegal channel
    run_req(3'd5, 1'b1, 4'd2, 1'b1, busy_n, hi, rises, bad_drv);
    check("badch_busy", busy_n, 0);
    check("badch_err", err_o, 2);
    n = 0;
    repeat (20) begin
      if (ps_pulse) n++;
      tick;
    end
    check("badch_no_pulse", n, 0);
    check("badch_phase", phase_o, 8'h3F);

    // Lock loss during the 2nd pulse of a 5-step advance on ch1
    check("ll_ready", req_ready, 1);
    req_valid = 1'b1;
    req_ch    = 3'd1;
    req_dir   = 1'b1;
    req_steps = (ABS != 0) ? 4'd8 : 4'd5;
    tick;
    req_valid = 1'b0;
    repeat (14 + ABS) tick;
    check("ll_pulse2_high", ps_pulse, 1);
    pll_lock = 1'b0;
    n = 0;
    while (ps_pulse && n < 6) begin
      tick;
      n++;
    end
    check("ll_drop_latency_ok", (n <= 3) ? 1 : 0, 1);
    check("ll_err", err_o, 3);
    check("ll_busy", busy, 0);
    check("ll_ready_low", req_ready, 0);
    check("ll_phase", phase_o, 8'h4F);
    repeat (5) tick;
    check("ll_no_more_pulse", ps_pulse, 0);

    // Relock
    pll_lock = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin
      tick;
      n++;
    end
    check("relock_ready", req_ready, 1);
    check("relock_rst_out", rst_out_n, 1);

`ifdef PLL_TUNER_ABS_EN
    // ch0: 15 -> 2 is a 3-step advance, then 2 -> 13 is a 5-step retard
    run_req(3'd0, 1'b0, 4'd2, 1'b1, busy_n, hi, rises, bad_drv);
    check("abs_a_count", rises, 3);
    check("abs_a_busy", busy_n, 38);
    check("abs_a_phase", phase_o, 8'h42);
    run_req(3'd0, 1'b1, 4'd13, 1'b0, busy_n, hi, rises, bad_drv);
    check("abs_r_count", rises, 5);
    check("abs_r_dir", bad_drv, 0);
    check("abs_r_busy", busy_n, 62);
    check("abs_r_phase", phase_o, 8'h4D);
`endif

    // Reset mid-pulse
    req_valid = 1'b1;
    req_ch    = 3'd1;
    req_dir   = 1'b1;
    req_steps = (ABS != 0) ? 4'd6 : 4'd2;
    tick;
    req_valid = 1'b0;
    repeat (3 + ABS) tick;
    check("mid_pulse_high", ps_pulse, 1);
    sys_rst_n = 1'b0;
    tick;
    check("mid_rst_pulse", ps_pulse, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_phase", phase_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_lock", lock_stable, 0);
    check("mid_rst_rst_out", rst_out_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
